// File: rtl/mem_bus_ctrl_if.sv
// Control-unit and memory-bus signals of mem_bus_ctrl.
// The slave modport is the controller's view; the master modport is the view of whatever drives it.
interface mem_bus_ctrl_if #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 12
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic [DATA_W-1:0] rdata;
    logic              mem_cs;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport slave (
        input  req, we, addr, wdata, mem_rdata, mem_ack,
        output busy, done, err, rdata, mem_cs, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req, we, addr, wdata, mem_rdata, mem_ack,
        input  busy, done, err, rdata, mem_cs, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_bus_ctrl.sv
// Single-request memory bus controller: IDLE -> SETUP -> ACCESS (ack or timeout) -> DONE.
// Every output is a register or a decode of the state register.
module mem_bus_ctrl #(
    parameter int DATA_W  = 24,
    parameter int ADDR_W  = 12,
    parameter int TIMEOUT = 16
) (
    input logic           clk,
    input logic           rst_n,
    mem_bus_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        DONE
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic [CNT_W-1:0]  cnt_q;

    logic accept;
    logic cnt_clr;
    logic cnt_inc;
    logic set_err;
    logic load_rd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Ack is tested before the count so a final-cycle ack still completes cleanly.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        set_err = 1'b0;
        load_rd = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    accept  = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                cnt_clr = 1'b1;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (bus.mem_ack) begin
                    load_rd = !we_q;
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    set_err = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if (accept) begin
                we_q    <= bus.we;
                addr_q  <= bus.addr;
                wdata_q <= bus.wdata;
                err_q   <= 1'b0;
            end
            if (set_err) begin
                err_q <= 1'b1;
            end
            if (cnt_clr) begin
                cnt_q <= '0;
            end else if (cnt_inc) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (load_rd) begin
                rdata_q <= bus.mem_rdata;
            end
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.mem_cs    = (state_q == ACCESS);
    assign bus.mem_we    = (state_q == ACCESS) && we_q;
    assign bus.err       = err_q;
    assign bus.rdata     = rdata_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: a transaction-timeline model predicts every output each cycle,
// and directed scenarios add literal expectations for latency, counts and held values.
module tb_mem_bus_ctrl;
    localparam int DATA_W  = 24;
    localparam int ADDR_W  = 12;
    localparam int TIMEOUT = 16;
    localparam int NO_ACK  = 255;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_bus_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    mem_bus_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Per-transaction memory behaviour: ack in ACCESS cycle w (0-based), or never if w >= TIMEOUT.
    typedef struct {
        int                w;
        logic [DATA_W-1:0] rd;
        bit                noise;
    } plan_t;
    plan_t plan_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model state: transaction accepted at edge N lasts L ACCESS cycles; SETUP is cycle N, DONE is N+1+L.
    int  E = 0, N = 0, L = 0;
    bit  have = 1'b0;
    bit  t_we = 1'b0, t_to = 1'b0;
    logic [DATA_W-1:0] t_rd = '0;
    int  ack_cyc = -1, noise_a = -1, noise_b = -1;
    int  accepts = 0, last_acc = 0;
    logic              exp_busy = 1'b0, exp_done = 1'b0, exp_cs = 1'b0, exp_mwe = 1'b0, exp_err = 1'b0;
    logic [DATA_W-1:0] exp_rdata = '0, exp_wdata = '0;
    logic [ADDR_W-1:0] exp_addr = '0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                E = 0; have = 1'b0; ack_cyc = -1; noise_a = -1; noise_b = -1;
                exp_busy = 1'b0; exp_done = 1'b0; exp_cs = 1'b0; exp_mwe = 1'b0; exp_err = 1'b0;
                exp_rdata = '0; exp_wdata = '0; exp_addr = '0;
            end else begin
                E = E + 1;
                if (bus.req === 1'b1 && (!have || E >= N + 3 + L)) begin
                    plan_t p;
                    if (plan_q.size() > 0) p = plan_q.pop_front();
                    else begin p.w = NO_ACK; p.rd = '0; p.noise = 1'b0; end
                    have = 1'b1; N = E;
                    t_we = bus.we; t_rd = p.rd;
                    t_to = (p.w >= TIMEOUT);
                    L = t_to ? TIMEOUT : p.w + 1;
                    ack_cyc = t_to ? -1 : N + 1 + p.w;
                    noise_a = p.noise ? N : -1;
                    noise_b = p.noise ? N + 1 + L : -1;
                    exp_err = 1'b0; exp_addr = bus.addr; exp_wdata = bus.wdata;
                    accepts++; last_acc = E;
                end
                if (have) begin
                    exp_busy = (E >= N) && (E <= N + 1 + L);
                    exp_done = (E == N + 1 + L);
                    exp_cs   = (E >= N + 1) && (E <= N + L);
                    exp_mwe  = exp_cs && t_we;
                    if (exp_done) begin
                        if (t_to) exp_err = 1'b1;
                        else if (!t_we) exp_rdata = t_rd;
                    end
                end
            end
        end
    end

    // Memory responder: acks on the planned cycle, optional spurious acks outside ACCESS.
    initial begin
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && E == ack_cyc) begin
                bus.mem_ack = 1'b1; bus.mem_rdata = t_rd;
            end else if (rst_n && (E == noise_a || E == noise_b)) begin
                bus.mem_ack = 1'b1; bus.mem_rdata = 24'hBADBAD;
            end else begin
                bus.mem_ack = 1'b0; bus.mem_rdata = DATA_W'(E) ^ 24'h5A0000;
            end
        end
    end

    int cs_cnt = 0, mwe_cnt = 0, done_cnt = 0, dut_done = 0, prev_done = 0;

    initial begin
        forever begin
            @(negedge clk);
            chk("busy",      32'(bus.busy),      32'(exp_busy));
            chk("done",      32'(bus.done),      32'(exp_done));
            chk("mem_cs",    32'(bus.mem_cs),    32'(exp_cs));
            chk("mem_we",    32'(bus.mem_we),    32'(exp_mwe));
            chk("err",       32'(bus.err),       32'(exp_err));
            chk("rdata",     32'(bus.rdata),     32'(exp_rdata));
            chk("mem_addr",  32'(bus.mem_addr),  32'(exp_addr));
            chk("mem_wdata", 32'(bus.mem_wdata), 32'(exp_wdata));
            if (bus.mem_cs === 1'b1) cs_cnt++;
            if (bus.mem_we === 1'b1) mwe_cnt++;
            if (bus.done === 1'b1) begin
                done_cnt++; prev_done = dut_done; dut_done = E;
            end
        end
    end

    int cs0 = 0, mwe0 = 0, d0 = 0, a0 = 0;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic snap();
        cs0 = cs_cnt; mwe0 = mwe_cnt; d0 = done_cnt; a0 = accepts;
    endtask

    task automatic start(input logic w_e, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd,
                         input int w, input logic [DATA_W-1:0] rd, input bit noise);
        plan_t p;
        p.w = w; p.rd = rd; p.noise = noise;
        plan_q.push_back(p);
        bus.we = w_e; bus.addr = a; bus.wdata = wd; bus.req = 1'b1;
        tick();
        bus.req = 1'b0;
    endtask

    task automatic wait_done(input int n, input string nm);
        for (int i = 0; i < 300 && done_cnt < d0 + n; i++) tick();
        chk(nm, 32'(done_cnt - d0), 32'(n));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1);
    end

    initial begin
        bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
        repeat (3) tick();
        chk("rst_busy",  32'(bus.busy),      32'h0);
        chk("rst_done",  32'(bus.done),      32'h0);
        chk("rst_err",   32'(bus.err),       32'h0);
        chk("rst_rdata", 32'(bus.rdata),     32'h0);
        chk("rst_cs",    32'(bus.mem_cs),    32'h0);
        chk("rst_we",    32'(bus.mem_we),    32'h0);
        chk("rst_addr",  32'(bus.mem_addr),  32'h0);
        chk("rst_wdata", 32'(bus.mem_wdata), 32'h0);
        rst_n = 1'b1;
        tick();

        // Read, ack in first ACCESS cycle
        snap();
        start(1'b0, 12'h012, 24'h000000, 0, 24'hA5A5A5, 1'b0);
        wait_done(1, "t1_done_count");
        tick();
        chk("t1_cs_cycles", 32'(cs_cnt - cs0), 32'd1);
        chk("t1_we_cycles", 32'(mwe_cnt - mwe0), 32'd0);
        chk("t1_latency",   32'(dut_done - last_acc), 32'd2);
        chk("t1_rdata",     32'(bus.rdata), 32'hA5A5A5);
        chk("t1_err",       32'(bus.err), 32'h0);

        // Write, ack after 3 wait cycles, spurious acks in SETUP and DONE
        snap();
        start(1'b1, 12'h3FF, 24'h123456, 3, 24'h000000, 1'b1);
        wait_done(1, "t2_done_count");
        tick();
        chk("t2_cs_cycles", 32'(cs_cnt - cs0), 32'd4);
        chk("t2_we_cycles", 32'(mwe_cnt - mwe0), 32'd4);
        chk("t2_rdata",     32'(bus.rdata), 32'hA5A5A5);
        chk("t2_addr",      32'(bus.mem_addr), 32'h3FF);
        chk("t2_wdata",     32'(bus.mem_wdata), 32'h123456);

        // Read that times out
        snap();
        start(1'b0, 12'h055, 24'h000000, NO_ACK, 24'h000000, 1'b0);
        wait_done(1, "t3_done_count");
        tick();
        chk("t3_cs_cycles", 32'(cs_cnt - cs0), 32'd16);
        chk("t3_err",       32'(bus.err), 32'h1);
        chk("t3_rdata",     32'(bus.rdata), 32'hA5A5A5);

        // Next read clears err at acceptance
        snap();
        start(1'b0, 12'h056, 24'h000000, 2, 24'h00FF00, 1'b0);
        chk("t3b_err_cleared", 32'(bus.err), 32'h0);
        wait_done(1, "t3b_done_count");
        tick();
        chk("t3b_rdata", 32'(bus.rdata), 32'h00FF00);

        // Ack in the final ACCESS cycle wins over the timeout
        snap();
        start(1'b0, 12'h057, 24'h000000, TIMEOUT - 1, 24'h777777, 1'b1);
        wait_done(1, "t4_done_count");
        tick();
        chk("t4_cs_cycles", 32'(cs_cnt - cs0), 32'd16);
        chk("t4_err",       32'(bus.err), 32'h0);
        chk("t4_rdata",     32'(bus.rdata), 32'h777777);

        // req pulses in SETUP, ACCESS and DONE are ignored
        snap();
        start(1'b0, 12'h0AA, 24'h000000, 5, 24'h111111, 1'b0);
        bus.req = 1'b1; bus.addr = 12'hFFF;
        tick();
        bus.req = 1'b0;
        tick();
        tick();
        bus.req = 1'b1;
        tick();
        bus.req = 1'b0;
        for (int i = 0; i < 50 && done_cnt == d0; i++) tick();
        bus.req = 1'b1;
        tick();
        bus.req = 1'b0;
        tick();
        chk("t5_done_count", 32'(done_cnt - d0), 32'd1);
        chk("t5_accepts",    32'(accepts - a0), 32'd1);
        chk("t5_addr",       32'(bus.mem_addr), 32'h0AA);

        // req held high: back-to-back reads every 4 cycles
        snap();
        begin
            plan_t p;
            p.noise = 1'b0; p.w = 0;
            p.rd = 24'h010101; plan_q.push_back(p);
            p.rd = 24'h020202; plan_q.push_back(p);
            p.rd = 24'h030303; plan_q.push_back(p);
        end
        bus.we = 1'b0; bus.addr = 12'h100; bus.req = 1'b1;
        for (int i = 0; i < 40 && accepts < a0 + 3; i++) tick();
        bus.req = 1'b0;
        wait_done(3, "t6_done_count");
        tick();
        chk("t6_spacing",   32'(dut_done - prev_done), 32'd4);
        chk("t6_cs_cycles", 32'(cs_cnt - cs0), 32'd3);
        chk("t6_rdata",     32'(bus.rdata), 32'h030303);

        // Asynchronous reset in the middle of ACCESS
        start(1'b0, 12'h200, 24'h000000, NO_ACK, 24'h000000, 1'b0);
        tick();
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        chk("t7_busy",  32'(bus.busy),   32'h0);
        chk("t7_cs",    32'(bus.mem_cs), 32'h0);
        chk("t7_err",   32'(bus.err),    32'h0);
        chk("t7_rdata", 32'(bus.rdata),  32'h0);
        chk("t7_done",  32'(bus.done),   32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        snap();
        start(1'b0, 12'h321, 24'h000000, 1, 24'hABCDEF, 1'b0);
        wait_done(1, "t8_done_count");
        tick();
        chk("t8_rdata",     32'(bus.rdata), 32'hABCDEF);
        chk("t8_err",       32'(bus.err), 32'h0);
        chk("t8_cs_cycles", 32'(cs_cnt - cs0), 32'd2);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
- Memory-side counterpart to the datapath's enable-loaded data registers.
- Accepts a single read or write request from the multicycle control unit and runs it as a chip-select/acknowledge transaction on the memory bus, with a timeout.
- Captures read data into an internal holding register and returns a one-cycle completion pulse.
- Sits between the control unit/datapath and the memory or I/O bus.

Parameters:
DATA_W, 24, data width of the datapath and the memory bus
ADDR_W, 12, memory address width
TIMEOUT, 16, maximum number of ACCESS cycles before the transaction aborts (legal range 2..255)

Ports:
clk  in  1  system clock; all state changes on the rising edge
rst_n  in  1  asynchronous active-low reset
req  in  1  start request from the control unit; sampled only in IDLE
we  in  1  1 = write, 0 = read; sampled together with req
addr  in  ADDR_W  transaction address; sampled together with req
wdata  in  DATA_W  write data; sampled together with req
busy  out  1  high from the cycle after acceptance through the DONE cycle
done  out  1  one-cycle completion pulse
err  out  1  last transaction timed out; held until the next acceptance
rdata  out  DATA_W  last successfully read word; held otherwise
mem_cs  out  1  memory chip select, high in ACCESS only
mem_we  out  1  memory write strobe; equals the latched we while mem_cs = 1, otherwise 0
mem_addr  out  ADDR_W  latched address
mem_wdata  out  DATA_W  latched write data
mem_rdata  in  DATA_W  memory read data, valid when mem_ack = 1
mem_ack  in  1  memory acknowledge

Behaviour:
- Reset (asynchronous, rst_n = 0, effective immediately, including mid-transaction):
  - state = IDLE.
  - busy, done, err, mem_cs, mem_we = 0.
  - rdata, mem_addr, mem_wdata, internal we latch and counter = 0.
- All outputs are registered or decoded from the state register only. No combinational path from an input to an output.
- FSM states are IDLE, SETUP, ACCESS, DONE.
- IDLE:
  - busy = 0.
  - If req = 1 at an edge: latch we, addr and wdata; clear err; go to SETUP.
  - If req = 0: stay in IDLE.
- SETUP (exactly 1 cycle):
  - mem_addr and mem_wdata are driven with the latched values; mem_cs = 0.
  - Clear the counter; go to ACCESS.
  - mem_ack is ignored in this state.
- ACCESS:
  - mem_cs = 1; mem_we = latched we.
  - At each edge:
    - If mem_ack = 1: for a read, load rdata <= mem_rdata; go to DONE.
    - Else if counter == TIMEOUT-1: set err = 1; go to DONE; rdata is unchanged.
    - Else: counter increments.
  - ACCESS therefore lasts at most TIMEOUT cycles.
  - If mem_ack = 1 arrives in the final cycle, the ack wins and err stays 0.
- DONE (exactly 1 cycle):
  - done = 1, busy = 1, mem_cs = 0; go to IDLE.
- Latency:
  - req is accepted at edge N; busy = 1 after edge N.
  - mem_cs rises after edge N+1.
  - With an ack during the first ACCESS cycle, done is high for the cycle following edge N+2.
  - Minimum issue rate is one transaction per 4 cycles.
- Requests:
  - req is ignored while busy = 1 (no queueing).
  - A req still held high in the IDLE cycle after DONE starts a new transaction.
- Held values:
  - mem_addr and mem_wdata hold their last values in IDLE.
  - Writes never modify rdata.
  - mem_ack outside ACCESS has no effect.

Test Plan:
- Reset, then a read at addr = 0x012 where memory acks in the first ACCESS cycle with mem_rdata = 0xA5A5A5 -> mem_cs is high for exactly 1 cycle, mem_we = 0, done pulses 2 edges after acceptance, rdata = 0xA5A5A5, err = 0.
- Write to addr = 0x3FF with wdata = 0x123456 and an ack after 3 wait cycles -> mem_cs is high for 4 cycles with mem_we = 1, mem_addr = 0x3FF, mem_wdata = 0x123456; a single done pulse; rdata keeps the previous 0xA5A5A5.
- Read with no ack (TIMEOUT = 16) -> mem_cs is high for exactly 16 cycles, then done = 1 and err = 1, and rdata is unchanged. A following read acked with 0x00FF00 clears err at acceptance and gives rdata = 0x00FF00.
- Ack asserted in the 16th (final) ACCESS cycle with 0x777777 -> err = 0, rdata = 0x777777.
- req toggled high during SETUP, ACCESS and DONE of an active transaction -> exactly one done pulse, and mem_addr is unchanged. req held continuously high -> back-to-back transactions every 4 cycles.
- rst_n pulled low mid-ACCESS -> mem_cs, busy and err drop to 0 and rdata goes to 0 without waiting for a clock edge. After release, a fresh read completes normally.
